// File: rtl/alu_operand_sequencer.sv
// Front end for the 4-bit ALU: debounces two buttons, steps operands and opcode
// into registers, then captures the ALU result one edge after it is presented.
module alu_operand_sequencer #(
   parameter int DATA_W       = 4,
   parameter int OP_W         = 3,
   parameter int DEBOUNCE_CYC = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] sw_data,
   input  logic [OP_W-1:0]   sw_op,
   input  logic              btn_next,
   input  logic              btn_clr,
   output logic [DATA_W-1:0] a,
   output logic [DATA_W-1:0] b,
   output logic [OP_W-1:0]   ctrl,
   output logic              op_valid,
   input  logic [DATA_W-1:0] res_in,
   input  logic              car_in,
   input  logic              of_in,
   output logic [DATA_W-1:0] res_q,
   output logic              car_q,
   output logic              of_q,
   output logic              res_valid,
   output logic [1:0]        state_o
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYC);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

   typedef enum logic [1:0] {
      S_A    = 2'd0,
      S_B    = 2'd1,
      S_OP   = 2'd2,
      S_EXEC = 2'd3
   } state_t;

   // Index 0 is the "next" button, index 1 the "clear" button.
   logic [1:0]       raw;
   logic [1:0]       sync1;
   logic [1:0]       sync2;
   logic [1:0]       deb;
   logic [1:0]       deb_d;
   logic [CNT_W-1:0] cnt [2];
   logic             next_press;
   logic             clr_press;

   assign raw = {btn_clr, btn_next};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1 <= '0;
         sync2 <= '0;
         deb   <= '0;
         deb_d <= '0;
         for (int i = 0; i < 2; i++) cnt[i] <= '0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         deb_d <= deb;
         for (int i = 0; i < 2; i++) begin
            // Any cycle agreeing with the accepted level restarts the window.
            if (sync2[i] != deb[i]) begin
               if (cnt[i] == CNT_LAST) begin
                  deb[i] <= sync2[i];
                  cnt[i] <= '0;
               end else begin
                  cnt[i] <= cnt[i] + CNT_W'(1);
               end
            end else begin
               cnt[i] <= '0;
            end
         end
      end
   end

   assign next_press = deb[0] & ~deb_d[0];
   assign clr_press  = deb[1] & ~deb_d[1];

   state_t state;
   state_t state_nx;
   logic   first;
   logic   load_a;
   logic   load_b;
   logic   load_op;
   logic   capture;
   logic   clear;

   always_comb begin
      state_nx = state;
      load_a   = 1'b0;
      load_b   = 1'b0;
      load_op  = 1'b0;
      capture  = 1'b0;
      clear    = 1'b0;
      if (clr_press) begin
         clear    = 1'b1;
         state_nx = S_A;
      end else begin
         // Capture is independent of next_press so a fast press cannot lose it.
         capture = (state == S_EXEC) && first;
         if (next_press) begin
            unique case (state)
               S_A:    begin load_a  = 1'b1; state_nx = S_B;    end
               S_B:    begin load_b  = 1'b1; state_nx = S_OP;   end
               S_OP:   begin load_op = 1'b1; state_nx = S_EXEC; end
               S_EXEC: state_nx = S_A;
               default: state_nx = S_A;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= S_A;
         op_valid  <= 1'b0;
         first     <= 1'b0;
         a         <= '0;
         b         <= '0;
         ctrl      <= '0;
         res_q     <= '0;
         car_q     <= 1'b0;
         of_q      <= 1'b0;
         res_valid <= 1'b0;
      end else begin
         state    <= state_nx;
         op_valid <= (state_nx == S_EXEC);
         if (clear) begin
            first     <= 1'b0;
            a         <= '0;
            b         <= '0;
            ctrl      <= '0;
            res_q     <= '0;
            car_q     <= 1'b0;
            of_q      <= 1'b0;
            res_valid <= 1'b0;
         end else begin
            if (load_a) begin
               a         <= sw_data;
               res_valid <= 1'b0;
            end
            if (load_b) b <= sw_data;
            if (load_op) begin
               ctrl  <= sw_op;
               first <= 1'b1;
            end
            if (capture) begin
               res_q     <= res_in;
               car_q     <= car_in;
               of_q      <= of_in;
               res_valid <= 1'b1;
               first     <= 1'b0;
            end
         end
      end
   end

   assign state_o = state;

endmodule
